// File: rtl/pwm_gen.sv
// pwm_gen: tick-driven PWM / pulse generator placed after the prescaler.
// Counts prescaler ticks to build a PWM waveform with programmable period
// and duty. It supports continuous and one-shot modes. Period/duty writes
// go to a pending register and reach the active (shadow) copy only while
// idle or on the tick that completes a period, so a write never produces
// a runt pulse.
//
// Ports:
//   clk          system clock (shared with the prescaler)
//   rst          asynchronous, active-high reset
//   tick_i       single-cycle tick enable; the counter advances only on it
//   en_i         global enable; low returns the block to IDLE at the next clk
//   mode_i       0 = continuous, 1 = one-shot; captured when a start is taken
//   start_i      level start request, honoured only in IDLE
//   load_i       capture period_i/duty_i into the pending registers
//   period_i     period in ticks
//   duty_i       high time in ticks
//   pwm_o        registered PWM output
//   period_end_o one-clk pulse after the tick that completes a period
//   busy_o       registered, high while in RUN
module pwm_gen #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             mode_i,
  input  logic             start_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] period_i,
  input  logic [CNT_W-1:0] duty_i,
  output logic             pwm_o,
  output logic             period_end_o,
  output logic             busy_o
);

  localparam int MAX_COUNTER_WIDTH = 32;

  generate
    if ((CNT_W < 2) || (CNT_W > MAX_COUNTER_WIDTH)) begin : g_bad_cnt_w
      $error("pwm_gen: CNT_W must be within 2..32");
    end
  endgenerate

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  state_t           state_r, state_nx_s;
  logic [CNT_W-1:0] cnt_r, cnt_nx_s;
  logic [CNT_W-1:0] pend_period_r, pend_duty_r;
  logic             pend_valid_r;
  logic [CNT_W-1:0] sh_period_r, sh_duty_r;
  logic [CNT_W-1:0] sh_period_nx_s, sh_duty_nx_s;
  logic             mode_sh_r, mode_nx_s;
  logic             complete_s;
  logic             xfer_s;
  logic             pwm_nx_s;
  logic             pwm_r, period_end_r, busy_r;

  // Period boundary detection and shadow-transfer decision.
  // en_i low outranks a coinciding tick, so no completion is seen then.
  always_comb begin
    complete_s = 1'b0;
    xfer_s     = 1'b0;
    if ((state_r == ST_RUN) && en_i && tick_i && (cnt_r == (sh_period_r - CNT_ONE))) begin
      complete_s = 1'b1;
    end else begin
      complete_s = 1'b0;
    end
    if (pend_valid_r && ((state_r == ST_IDLE) || complete_s)) begin
      xfer_s = 1'b1;
    end else begin
      xfer_s = 1'b0;
    end
    // Values the shadow copies will hold after this edge; the start and
    // restart decisions use these, not the stale shadow contents.
    if (xfer_s) begin
      sh_period_nx_s = pend_period_r;
      sh_duty_nx_s   = pend_duty_r;
    end else begin
      sh_period_nx_s = sh_period_r;
      sh_duty_nx_s   = sh_duty_r;
    end
  end

  // Next-state, next-count and next-output logic for the IDLE/RUN FSM.
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    mode_nx_s  = mode_sh_r;
    case (state_r)
      ST_IDLE: begin
        cnt_nx_s = CNT_ZERO;
        if (en_i && start_i && (sh_period_nx_s != CNT_ZERO)) begin
          state_nx_s = ST_RUN;
          mode_nx_s  = mode_i;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!en_i) begin
          state_nx_s = ST_IDLE;
          cnt_nx_s   = CNT_ZERO;
        end else if (complete_s) begin
          cnt_nx_s = CNT_ZERO;
          if (mode_sh_r || (sh_period_nx_s == CNT_ZERO)) begin
            state_nx_s = ST_IDLE;
          end else begin
            state_nx_s = ST_RUN;
          end
        end else if (tick_i) begin
          cnt_nx_s = cnt_r + CNT_ONE;
        end else begin
          cnt_nx_s = cnt_r;
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        cnt_nx_s   = CNT_ZERO;
      end
    endcase
    // Output is computed from the post-edge state so it lines up with cnt.
    pwm_nx_s = (state_nx_s == ST_RUN) && (cnt_nx_s < sh_duty_nx_s);
  end

  // FSM state, counter, captured mode and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      cnt_r        <= CNT_ZERO;
      mode_sh_r    <= 1'b0;
      pwm_r        <= 1'b0;
      period_end_r <= 1'b0;
      busy_r       <= 1'b0;
    end else begin
      state_r      <= state_nx_s;
      cnt_r        <= cnt_nx_s;
      mode_sh_r    <= mode_nx_s;
      pwm_r        <= pwm_nx_s;
      period_end_r <= complete_s;
      busy_r       <= (state_nx_s == ST_RUN);
    end
  end

  // Pending and shadow period/duty registers. A load in the same cycle as
  // a transfer refills pending while the transfer takes the old values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_period_r <= CNT_ZERO;
      pend_duty_r   <= CNT_ZERO;
      pend_valid_r  <= 1'b0;
      sh_period_r   <= CNT_ZERO;
      sh_duty_r     <= CNT_ZERO;
    end else begin
      sh_period_r <= sh_period_nx_s;
      sh_duty_r   <= sh_duty_nx_s;
      if (load_i) begin
        pend_period_r <= period_i;
        pend_duty_r   <= duty_i;
        pend_valid_r  <= 1'b1;
      end else if (xfer_s) begin
        pend_valid_r <= 1'b0;
      end else begin
        pend_valid_r <= pend_valid_r;
      end
    end
  end

  assign pwm_o        = pwm_r;
  assign period_end_o = period_end_r;
  assign busy_o       = busy_r;

endmodule

// File: tb/tb_pwm_gen.sv
// Directed testbench for pwm_gen: a 16-bit instance carries the main
// scenarios, and a 32-bit instance covers the full-width counter.
module tb_pwm_gen;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        tick_i = 1'b0;
  logic        en_i = 1'b1;
  logic        mode_i = 1'b0;
  logic        start_i = 1'b0;
  logic        load_i = 1'b0;
  logic [15:0] period_i = 16'd0;
  logic [15:0] duty_i = 16'd0;
  logic        pwm_o, period_end_o, busy_o;

  logic        start32 = 1'b0;
  logic        load32 = 1'b0;
  logic [31:0] period32 = 32'd0;
  logic [31:0] duty32 = 32'd0;
  logic        pwm32, pe32, busy32;

  int checks = 0;
  int errors = 0;

  pwm_gen #(.CNT_W(16)) dut (
    .clk(clk), .rst(rst), .tick_i(tick_i), .en_i(en_i), .mode_i(mode_i),
    .start_i(start_i), .load_i(load_i), .period_i(period_i), .duty_i(duty_i),
    .pwm_o(pwm_o), .period_end_o(period_end_o), .busy_o(busy_o)
  );

  pwm_gen #(.CNT_W(32)) dut32 (
    .clk(clk), .rst(rst), .tick_i(tick_i), .en_i(1'b1), .mode_i(1'b0),
    .start_i(start32), .load_i(load32), .period_i(period32), .duty_i(duty32),
    .pwm_o(pwm32), .period_end_o(pe32), .busy_o(busy32)
  );

  always #5 clk = ~clk;

  // One clock with the given tick level; returns 1 time unit after the edge.
  task automatic cyc(input logic t);
    tick_i = t;
    @(posedge clk);
    #1;
    tick_i = 1'b0;
  endtask

  task automatic do_load(input logic [15:0] p, input logic [15:0] d);
    period_i = p;
    duty_i   = d;
    load_i   = 1'b1;
    cyc(1'b0);
    load_i   = 1'b0;
  endtask

  task automatic do_start(input logic m);
    mode_i  = m;
    start_i = 1'b1;
    cyc(1'b0);
    start_i = 1'b0;
  endtask

  task automatic do_stop();
    en_i = 1'b0;
    cyc(1'b0);
    en_i = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    checks++;
    if ({pwm_o, period_end_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_outputs got=%b exp=000", {pwm_o, period_end_o, busy_o});
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc(1'b0);
    checks++;
    if ({pwm_o, period_end_o, busy_o} !== 3'b000) begin
      errors++;
      $display("FAIL reset_release got=%b exp=000", {pwm_o, period_end_o, busy_o});
    end
  endtask

  task automatic test_continuous();
    do_load(16'd4, 16'd1);
    do_start(1'b0);
    checks++;
    if ({busy_o, pwm_o} !== 2'b11) begin
      errors++;
      $display("FAIL cont_start got=%b exp=11", {busy_o, pwm_o});
    end
    for (int t = 1; t <= 12; t++) begin
      cyc(1'b0);
      checks++;
      if (period_end_o !== 1'b0) begin
        errors++;
        $display("FAIL cont_pe_gap t=%0d got=%b exp=0", t, period_end_o);
      end
      cyc(1'b0);
      cyc(1'b1);
      checks++;
      if ((pwm_o !== ((t % 4) < 1)) || (period_end_o !== ((t % 4) == 0))) begin
        errors++;
        $display("FAIL cont_tick t=%0d got pwm=%b pe=%b exp pwm=%b pe=%b",
                 t, pwm_o, period_end_o, ((t % 4) < 1), ((t % 4) == 0));
      end
    end
    do_stop();
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL cont_stop got=%b exp=0", busy_o);
    end
  endtask

  task automatic test_double_buffer();
    int c;
    do_load(16'd8, 16'd4);
    do_start(1'b0);
    checks++;
    if (pwm_o !== 1'b1) begin
      errors++;
      $display("FAIL dbuf_start got=%b exp=1", pwm_o);
    end
    for (int t = 1; t <= 16; t++) begin
      if (t == 3) begin
        do_load(16'd4, 16'd2);
      end else begin
        cyc(1'b0);
      end
      cyc(1'b1);
      c = (t - 8) % 4;
      if (t < 8) begin
        checks++;
        if ((pwm_o !== (t < 4)) || (period_end_o !== 1'b0)) begin
          errors++;
          $display("FAIL dbuf_old t=%0d got pwm=%b pe=%b exp pwm=%b pe=0",
                   t, pwm_o, period_end_o, (t < 4));
        end
      end else begin
        checks++;
        if ((pwm_o !== (c < 2)) || (period_end_o !== (c == 0))) begin
          errors++;
          $display("FAIL dbuf_new t=%0d got pwm=%b pe=%b exp pwm=%b pe=%b",
                   t, pwm_o, period_end_o, (c < 2), (c == 0));
        end
      end
    end
    do_stop();
  endtask

  task automatic test_one_shot();
    do_load(16'd5, 16'd3);
    mode_i  = 1'b1;
    start_i = 1'b1;
    cyc(1'b0);
    checks++;
    if ({busy_o, pwm_o} !== 2'b11) begin
      errors++;
      $display("FAIL oneshot_start got=%b exp=11", {busy_o, pwm_o});
    end
    for (int t = 1; t <= 5; t++) begin
      cyc(1'b0);
      cyc(1'b1);
      checks++;
      if ((pwm_o !== (t < 3)) || (busy_o !== (t < 5)) || (period_end_o !== (t == 5))) begin
        errors++;
        $display("FAIL oneshot_tick t=%0d got pwm=%b busy=%b pe=%b exp pwm=%b busy=%b pe=%b",
                 t, pwm_o, busy_o, period_end_o, (t < 3), (t < 5), (t == 5));
      end
    end
    cyc(1'b0);
    checks++;
    if ({busy_o, pwm_o, period_end_o} !== 3'b110) begin
      errors++;
      $display("FAIL oneshot_retrigger got=%b exp=110", {busy_o, pwm_o, period_end_o});
    end
    start_i = 1'b0;
    mode_i  = 1'b0;
    do_stop();
  endtask

  task automatic test_boundaries();
    do_load(16'd3, 16'd0);
    do_start(1'b0);
    checks++;
    if ({busy_o, pwm_o} !== 2'b10) begin
      errors++;
      $display("FAIL duty0_start got=%b exp=10", {busy_o, pwm_o});
    end
    for (int t = 1; t <= 6; t++) begin
      cyc(1'b0);
      cyc(1'b1);
      checks++;
      if (pwm_o !== 1'b0) begin
        errors++;
        $display("FAIL duty0_tick t=%0d got=%b exp=0", t, pwm_o);
      end
    end
    do_stop();
    do_load(16'd6, 16'd6);
    do_start(1'b0);
    for (int t = 1; t <= 13; t++) begin
      cyc(1'b1);
      checks++;
      if ((pwm_o !== 1'b1) || (busy_o !== 1'b1) || (period_end_o !== ((t % 6) == 0))) begin
        errors++;
        $display("FAIL full_tick t=%0d got pwm=%b busy=%b pe=%b exp pwm=1 busy=1 pe=%b",
                 t, pwm_o, busy_o, period_end_o, ((t % 6) == 0));
      end
    end
    do_stop();
    do_load(16'd0, 16'd0);
    start_i = 1'b1;
    for (int t = 0; t < 3; t++) begin
      cyc(1'b1);
      checks++;
      if ({busy_o, pwm_o} !== 2'b00) begin
        errors++;
        $display("FAIL period0 t=%0d got=%b exp=00", t, {busy_o, pwm_o});
      end
    end
    start_i = 1'b0;
  endtask

  task automatic test_priority();
    do_load(16'd3, 16'd1);
    do_start(1'b0);
    cyc(1'b1);
    cyc(1'b1);
    en_i = 1'b0;
    cyc(1'b1);
    en_i = 1'b1;
    checks++;
    if ({busy_o, period_end_o, pwm_o} !== 3'b000) begin
      errors++;
      $display("FAIL prio_en_tick got=%b exp=000", {busy_o, period_end_o, pwm_o});
    end
    cyc(1'b1);
    checks++;
    if ({busy_o, period_end_o, pwm_o} !== 3'b000) begin
      errors++;
      $display("FAIL prio_idle_tick got=%b exp=000", {busy_o, period_end_o, pwm_o});
    end
    do_start(1'b0);
    checks++;
    if ({busy_o, pwm_o} !== 2'b11) begin
      errors++;
      $display("FAIL prio_restart got=%b exp=11", {busy_o, pwm_o});
    end
    cyc(1'b1);
    cyc(1'b1);
    checks++;
    if ({pwm_o, period_end_o} !== 2'b00) begin
      errors++;
      $display("FAIL prio_cnt2 got=%b exp=00", {pwm_o, period_end_o});
    end
    cyc(1'b1);
    checks++;
    if ({pwm_o, period_end_o} !== 2'b11) begin
      errors++;
      $display("FAIL prio_wrap got=%b exp=11", {pwm_o, period_end_o});
    end
    do_stop();
  endtask

  task automatic test_wide_counter();
    period32 = 32'hFFFF_FFFF;
    duty32   = 32'hFFFF_FFFE;
    load32   = 1'b1;
    cyc(1'b0);
    load32   = 1'b0;
    start32  = 1'b1;
    cyc(1'b0);
    start32  = 1'b0;
    checks++;
    if ({busy32, pwm32} !== 2'b11) begin
      errors++;
      $display("FAIL wide_start got=%b exp=11", {busy32, pwm32});
    end
    repeat (3) cyc(1'b1);
    checks++;
    if ((dut32.cnt_r !== 32'd3) || (pwm32 !== 1'b1) || (pe32 !== 1'b0)) begin
      errors++;
      $display("FAIL wide_count got cnt=%h pwm=%b pe=%b exp cnt=00000003 pwm=1 pe=0",
               dut32.cnt_r, pwm32, pe32);
    end
  endtask

  task automatic test_reset_mid_run();
    do_load(16'd10, 16'd6);
    do_start(1'b0);
    repeat (5) cyc(1'b1);
    checks++;
    if ({busy_o, pwm_o} !== 2'b11) begin
      errors++;
      $display("FAIL rstrun_pre got=%b exp=11", {busy_o, pwm_o});
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if ({pwm_o, period_end_o, busy_o, pwm32, busy32} !== 5'b00000) begin
      errors++;
      $display("FAIL rstrun_async got=%b exp=00000",
               {pwm_o, period_end_o, busy_o, pwm32, busy32});
    end
    repeat (2) @(posedge clk);
    #3 rst = 1'b0;
    cyc(1'b1);
    checks++;
    if ({busy_o, pwm_o, period_end_o} !== 3'b000) begin
      errors++;
      $display("FAIL rstrun_idle got=%b exp=000", {busy_o, pwm_o, period_end_o});
    end
    // Shadow period was cleared, so a start without a load must not run.
    start_i = 1'b1;
    cyc(1'b0);
    cyc(1'b0);
    start_i = 1'b0;
    checks++;
    if (busy_o !== 1'b0) begin
      errors++;
      $display("FAIL rstrun_shadow_clear got=%b exp=0", busy_o);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_double_buffer();
    test_one_shot();
    test_boundaries();
    test_priority();
    test_wide_counter();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_gen.md
Name: pwm_gen

Overview:
- PWM / pulse generator that sits directly downstream of the prescaler.
- Consumes the prescaler's single-cycle tick enable and counts ticks to produce a PWM waveform with programmable period and duty.
- Supports continuous and one-shot modes.
- Period/duty updates are double-buffered and take effect only at a period boundary, so no runt pulses occur.

Parameters:
- CNT_W, 16, width of period/duty/counter; legal range 2..prescaler_lib::MAX_COUNTER_WIDTH (32); elaboration error outside range.

Ports:
- clk  in  1  system clock; same clock as prescaler.
- rst  in  1  reset; asynchronous, active-high.
- tick_i  in  1  prescaler tick enable; one clk wide; counter advances only when high.
- en_i  in  1  global enable; low forces IDLE at the next clk.
- mode_i  in  1  0 = continuous, 1 = one-shot; sampled on start.
- start_i  in  1  start request; level-sampled, acted on in IDLE only.
- load_i  in  1  capture period_i/duty_i into the pending registers.
- period_i  in  CNT_W  period in ticks.
- duty_i  in  CNT_W  high time in ticks.
- pwm_o  out  1  PWM output; registered.
- period_end_o  out  1  one-clk pulse on the tick that completes a period.
- busy_o  out  1  high while in RUN.

Behaviour:
- Reset values (async assert, sync deassert handled by the top level):
  - State IDLE, cnt=0, pwm_o=0, period_end_o=0, busy_o=0.
  - Pending and shadow period/duty = 0; pend_valid=0; mode_sh=0.
- Registers:
  - pend_period/pend_duty and pend_valid are set by load_i.
  - sh_period/sh_duty are the active copies.
  - A later load_i before the boundary overwrites pending (last write wins).
- Shadow transfer:
  - Occurs when pend_valid=1 AND (state=IDLE OR a period-completing tick occurs).
  - Clears pend_valid.
  - load_i in the same cycle as a transfer: the new values go to pending and pend_valid stays 1; the transfer uses the old pending values.
- FSM states: IDLE, RUN.
  - IDLE -> RUN: en_i=1 AND start_i=1 AND effective period != 0. Effective period is the pending value if a transfer happens this cycle, else sh_period. cnt <= 0; mode_sh <= mode_i.
  - RUN, tick_i=1, cnt != sh_period-1: cnt <= cnt+1.
  - RUN, tick_i=1, cnt == sh_period-1 (period complete):
    - period_end_o=1 next cycle; cnt <= 0; shadow transfer if pending.
    - mode_sh=1: go to IDLE.
    - mode_sh=0: stay in RUN. If the new sh_period = 0, go to IDLE.
  - RUN, en_i=0: go to IDLE immediately; cnt <= 0; no period_end_o.
  - en_i=0 has priority over tick_i in the same cycle.
- pwm_o:
  - Registered: pwm_o <= (next_state=RUN) AND (next_cnt < next_sh_duty). pwm_o is therefore aligned with the cnt/state it describes.
  - sh_duty >= sh_period gives constant high (100%) while in RUN.
  - sh_duty = 0 gives constant low.
- busy_o: registered, equals (state=RUN).
- Latency:
  - Start accepted at edge k: busy_o=1 and pwm_o valid after edge k.
  - First counter increment on the first tick_i after entering RUN.
- Arithmetic: unsigned CNT_W compare; cnt never exceeds sh_period-1; no wrap beyond the period.
- start_i while in RUN: ignored.
- tick_i while in IDLE: ignored.

Test Plan:
- Reset mid-RUN (period 10, cnt 5): assert rst -> all outputs 0 asynchronously; after release stays IDLE with cnt=0.
- Continuous run: load period=4 duty=1, start with mode=0, tick every 3rd clk -> pwm_o high for 1 tick, low for 3, repeating; period_end_o pulses once per 4 ticks.
- Double-buffer:
  - Running period=8 duty=4; load period=4 duty=2 at cnt=2 -> current period completes with 4 high / 4 low.
  - Next periods are 2 high / 2 low; no short pulse at the switch.
- One-shot: period=5 duty=3, mode=1, start -> exactly one 3-tick high pulse, one period_end_o, busy_o drops on the same edge as period_end_o rises; start held high afterwards re-triggers.
- Boundaries:
  - duty=0 -> pwm_o always 0.
  - duty=period=6 -> pwm_o constant 1.
  - period=0 with start -> stays IDLE, busy_o=0.
  - CNT_W=32 with period=2^32-1 -> cnt reaches 0xFFFFFFFE, then 0.
- Priority: en_i=0 coinciding with a completing tick -> IDLE, no period_end_o; tick_i in IDLE -> no state change.
